cu_vertex_job_dispatcher: RTL and testbench

//  Distributes vertex jobs from one graph_cu's vertex job buffer (CU_VERTEX_JOB_BUFFER_SIZE deep, upstream) across its
//  NUM_VERTEX_CU_GLOBAL vertex_cu's. Round-robin over idle CUs, one job in flight per CU, one dispatch per cycle.

---
 rtl/cu_vertex_job_dispatcher_pkg.sv | 25 ++
 rtl/cu_vertex_job_dispatcher_rr_idle_arbiter.sv | 33 +++
 rtl/cu_vertex_job_dispatcher.sv | 130 +++++++++++++
 tb/tb_cu_vertex_job_dispatcher.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_vertex_job_dispatcher_pkg.sv
// Shared types for the vertex job dispatcher: job payload, FSM states and the
// default vertex_cu count used by a graph_cu.
package cu_vertex_job_dispatcher_pkg;

  localparam int NUM_VERTEX_CU_GLOBAL = 4;

  typedef struct packed {
    logic [31:0] vertex_id;
    logic [31:0] edges_idx;
    logic [31:0] degree;
  } vertex_job_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_DONE     = 3'd4
  } vertex_dispatch_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cu_vertex_job_dispatcher_rr_idle_arbiter.sv
// Combinational round-robin pick: first requesting (idle) CU at or after ptr,
// wrapping modulo N. Returns one-hot grant, its index and whether any was found.
module cu_vertex_job_dispatcher_rr_idle_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      // ptr + k folded back into [0, N) without a divider
      cand = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N)) cand = cand - (IDX_W + 1)'(N);
      if (!grant_valid && req[cand[IDX_W-1:0]]) begin
        grant_valid                = 1'b1;
        grant[cand[IDX_W-1:0]]     = 1'b1;
        grant_idx                  = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cu_vertex_job_dispatcher.sv
// Hands vertex jobs from the graph_cu job buffer to idle vertex_cu's, one per
// cycle, round-robin, and tracks completions until the programmed count retires.
module cu_vertex_job_dispatcher
  import cu_vertex_job_dispatcher_pkg::*;
#(
  parameter int NUM_VERTEX_CU = NUM_VERTEX_CU_GLOBAL,
  parameter int CNT_W         = 32
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   enabled,
  input  logic [CNT_W-1:0]       num_vertices,
  input  logic                   job_in_valid,
  input  vertex_job_t            job_in,
  output logic                   job_in_ready,
  output logic [NUM_VERTEX_CU-1:0] cu_job_valid,
  output vertex_job_t            cu_job,
  input  logic [NUM_VERTEX_CU-1:0] cu_done,
  output logic [CNT_W-1:0]       jobs_completed,
  output logic                   dispatch_done,
  output logic                   protocol_error,
  output vertex_dispatch_state_e dbg_state
);

  // Handshake: a job transfers on the cycle job_in_valid && job_in_ready are
  // both high at the rising clock edge. job_in_ready never looks at
  // job_in_valid; the chosen CU sees cu_job_valid one cycle later.

  localparam int IDX_W = idx_width(NUM_VERTEX_CU);

  vertex_dispatch_state_e state, state_next;
  logic [NUM_VERTEX_CU-1:0] busy;
  logic [IDX_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]         n_q;
  logic [CNT_W-1:0]         dispatched;
  logic [CNT_W-1:0]         completed;

  logic [NUM_VERTEX_CU-1:0] grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_valid;
  logic [IDX_W-1:0]         next_ptr;
  logic [NUM_VERTEX_CU-1:0] done_hits;
  logic [CNT_W-1:0]         done_count;
  logic                     stray_done;
  logic                     abort;
  logic                     run_start;
  logic                     dispatch_fire;

  cu_vertex_job_dispatcher_rr_idle_arbiter #(
    .N     (NUM_VERTEX_CU),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (~busy),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign job_in_ready  = (state == ST_DISPATCH) && grant_valid && (dispatched < n_q);
  assign abort         = !enabled && ((state == ST_SETUP) || (state == ST_DISPATCH) ||
                                      (state == ST_DRAIN));
  assign run_start     = (state == ST_IDLE) && enabled;
  assign dispatch_fire = job_in_valid && job_in_ready && !abort;
  assign next_ptr      = (grant_idx == IDX_W'(NUM_VERTEX_CU - 1)) ? '0 : grant_idx + 1'b1;
  assign done_hits     = cu_done & busy;
  assign stray_done    = |(cu_done & ~busy);

  always_comb begin
    done_count = '0;
    for (int i = 0; i < NUM_VERTEX_CU; i++) begin
      done_count = done_count + CNT_W'(done_hits[i]);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (enabled) state_next = ST_SETUP;
      ST_SETUP:    if (!enabled) state_next = ST_IDLE;
                   else if (n_q == '0) state_next = ST_DONE;
                   else state_next = ST_DISPATCH;
      ST_DISPATCH: if (!enabled) state_next = ST_IDLE;
                   else if (dispatched == n_q) state_next = ST_DRAIN;
      ST_DRAIN:    if (!enabled) state_next = ST_IDLE;
                   else if (completed == n_q) state_next = ST_DONE;
      ST_DONE:     if (!enabled) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      busy           <= '0;
      rr_ptr         <= '0;
      n_q            <= '0;
      dispatched     <= '0;
      completed      <= '0;
      cu_job_valid   <= '0;
      cu_job         <= '0;
      protocol_error <= 1'b0;
    end else begin
      state        <= state_next;
      cu_job_valid <= dispatch_fire ? grant : '0;
      if (dispatch_fire) begin
        cu_job <= job_in;
        rr_ptr <= next_ptr;
      end
      if (run_start) begin
        n_q            <= num_vertices;
        dispatched     <= '0;
        completed      <= '0;
        protocol_error <= 1'b0;
      end else begin
        if (dispatch_fire) dispatched <= dispatched + CNT_W'(1);
        completed <= completed + done_count;
        if (stray_done) protocol_error <= 1'b1;
      end
      // A CU granted this cycle was idle, so its done bit cannot collide here
      if (abort) busy <= '0;
      else       busy <= (busy & ~cu_done) | (dispatch_fire ? grant : '0);
    end
  end

  assign jobs_completed = completed;
  assign dispatch_done  = (state == ST_DONE);
  assign dbg_state      = state;

endmodule

// File: tb/tb_cu_vertex_job_dispatcher.sv
// Bench for cu_vertex_job_dispatcher: directed scenarios plus randomized runs
// checked against a behavioural job/CU occupancy model.
module tb_cu_vertex_job_dispatcher;
  import cu_vertex_job_dispatcher_pkg::*;

  localparam int NCU = 4;
  localparam int P_IDLE = 0, P_SETUP = 1, P_DISP = 2, P_DRAIN = 3, P_DONE = 4;

  logic                   clock = 1'b0;
  logic                   rstn;
  logic                   enabled;
  logic [31:0]            num_vertices;
  logic                   job_in_valid;
  vertex_job_t            job_in;
  logic                   job_in_ready;
  logic [NCU-1:0]         cu_job_valid;
  vertex_job_t            cu_job;
  logic [NCU-1:0]         cu_done;
  logic [31:0]            jobs_completed;
  logic                   dispatch_done;
  logic                   protocol_error;
  vertex_dispatch_state_e dbg_state;

  cu_vertex_job_dispatcher #(.NUM_VERTEX_CU(NCU), .CNT_W(32)) dut (
    .clock          (clock),
    .rstn           (rstn),
    .enabled        (enabled),
    .num_vertices   (num_vertices),
    .job_in_valid   (job_in_valid),
    .job_in         (job_in),
    .job_in_ready   (job_in_ready),
    .cu_job_valid   (cu_job_valid),
    .cu_job         (cu_job),
    .cu_done        (cu_done),
    .jobs_completed (jobs_completed),
    .dispatch_done  (dispatch_done),
    .protocol_error (protocol_error),
    .dbg_state      (dbg_state)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total_cnt = 0;

  // behavioural model: which CUs hold a job, where the search starts, counts
  int          m_phase;
  logic [3:0]  m_busy;
  int          m_rr;
  logic [31:0] m_n, m_disp, m_comp;
  logic        m_err;
  logic [3:0]  m_valid;
  vertex_job_t m_job;
  logic [95:0] exp_q[$];

  function automatic vertex_job_t rand_job();
    vertex_job_t j;
    j.vertex_id = $urandom();
    j.edges_idx = $urandom();
    j.degree    = $urandom();
    return j;
  endfunction

  function automatic logic m_ready();
    return (m_phase == P_DISP) && (m_busy != 4'hf) && (m_disp < m_n);
  endfunction

  function automatic int m_grant();
    for (int off = 0; off < NCU; off++) begin
      if (!m_busy[(m_rr + off) % NCU]) return (m_rr + off) % NCU;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_busy = '0; m_rr = 0; m_n = '0; m_disp = '0; m_comp = '0;
    m_err = 1'b0; m_valid = '0; m_job = '0;
    exp_q.delete();
  endtask

  // advance model by one clock using the inputs currently driven, then clock the DUT
  task automatic tick();
    logic rdy, hs, abort, start;
    int g, nphase;
    logic [3:0] nb;
    rdy   = m_ready();
    g     = m_grant();
    hs    = job_in_valid && rdy;
    abort = !enabled && (m_phase == P_SETUP || m_phase == P_DISP || m_phase == P_DRAIN);
    start = (m_phase == P_IDLE) && enabled;
    nb    = m_busy;
    nphase = m_phase;
    case (m_phase)
      P_IDLE:  if (enabled) nphase = P_SETUP;
      P_SETUP: nphase = !enabled ? P_IDLE : (m_n == 0) ? P_DONE : P_DISP;
      P_DISP:  if (!enabled) nphase = P_IDLE; else if (m_disp == m_n) nphase = P_DRAIN;
      P_DRAIN: if (!enabled) nphase = P_IDLE; else if (m_comp == m_n) nphase = P_DONE;
      default: if (!enabled) nphase = P_IDLE;
    endcase
    if (start) begin
      m_n = num_vertices; m_disp = '0; m_comp = '0; m_err = 1'b0;
    end else begin
      for (int i = 0; i < NCU; i++) begin
        if (cu_done[i]) begin
          if (m_busy[i]) begin nb[i] = 1'b0; m_comp = m_comp + 1; end
          else m_err = 1'b1;
        end
      end
    end
    m_valid = '0;
    if (hs && !abort) begin
      nb[g] = 1'b1;
      m_disp = m_disp + 1;
      m_rr = (g + 1) % NCU;
      m_valid = 4'(1 << g);
      m_job = job_in;
      exp_q.push_back(job_in);
    end
    if (abort) nb = '0;
    m_busy = nb;
    m_phase = nphase;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0; enabled = 1'b0; num_vertices = '0; job_in_valid = 1'b0;
    job_in = '0; cu_done = '0;
    model_reset();
    @(negedge clock);
    rstn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enabled = 1'b0; num_vertices = '0; job_in_valid = 1'b0;
    job_in = '0; cu_done = '0;
    #3;
    total_cnt++;
    if ({cu_job_valid, cu_job, job_in_ready, jobs_completed, dispatch_done, protocol_error} !== '0)
      $display("FAIL reset_outputs act valid=%b job=%h rdy=%b comp=%0d done=%b err=%b req all 0",
               cu_job_valid, cu_job, job_in_ready, jobs_completed, dispatch_done, protocol_error);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== ST_IDLE) $display("FAIL reset_state act=%0d req=%0d", dbg_state, ST_IDLE);
    else pass_cnt++;
    apply_reset();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    enabled = 1'b1; num_vertices = 32'd4;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      job_in = rand_job(); job_in_valid = 1'b1; #1;
      total_cnt++;
      if (job_in_ready !== 1'b1) $display("FAIL b2b_ready%0d act=%b req=1", k, job_in_ready);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (cu_job_valid !== 4'(1 << k) || cu_job !== job_in)
        $display("FAIL b2b_grant%0d act=%b/%h req=%b/%h", k, cu_job_valid, cu_job, 4'(1 << k), job_in);
      else pass_cnt++;
    end
    #1;
    total_cnt++;
    if (job_in_ready !== 1'b0) $display("FAIL b2b_ready_after act=%b req=0", job_in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dbg_state !== ST_DRAIN || cu_job_valid !== 4'b0 || dispatch_done !== 1'b0)
      $display("FAIL b2b_drain act=%0d/%b/%b req=%0d/0000/0", dbg_state, cu_job_valid, dispatch_done, ST_DRAIN);
    else pass_cnt++;
    job_in_valid = 1'b0; enabled = 1'b0;
    tick();
    total_cnt++;
    if (dbg_state !== ST_IDLE || dispatch_done !== 1'b0)
      $display("FAIL b2b_abort act=%0d/%b req=%0d/0", dbg_state, dispatch_done, ST_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_refill();
    apply_reset();
    enabled = 1'b1; num_vertices = 32'd6;
    tick(); tick();
    job_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin job_in = rand_job(); tick(); end
    cu_done = 4'b0010; job_in = rand_job(); #1;
    total_cnt++;
    if (job_in_ready !== 1'b0) $display("FAIL refill_full act=%b req=0", job_in_ready);
    else pass_cnt++;
    tick(); cu_done = '0; #1;
    total_cnt++;
    if (jobs_completed !== 32'd1 || job_in_ready !== 1'b1)
      $display("FAIL refill_one act=%0d/%b req=1/1", jobs_completed, job_in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cu_job_valid !== 4'b0010 || cu_job !== job_in)
      $display("FAIL refill_cu1 act=%b/%h req=0010/%h", cu_job_valid, cu_job, job_in);
    else pass_cnt++;
    job_in = rand_job(); #1;
    total_cnt++;
    if (job_in_ready !== 1'b0) $display("FAIL refill_wait act=%b req=0", job_in_ready);
    else pass_cnt++;
    tick();
    cu_done = 4'b1111;
    tick(); cu_done = '0;
    total_cnt++;
    if (jobs_completed !== 32'd5) $display("FAIL refill_pop4 act=%0d req=5", jobs_completed);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cu_job_valid !== 4'b0100) $display("FAIL refill_sixth act=%b req=0100", cu_job_valid);
    else pass_cnt++;
    job_in_valid = 1'b0;
    tick();
    cu_done = 4'b0100;
    tick(); cu_done = '0;
    total_cnt++;
    if (jobs_completed !== 32'd6 || dispatch_done !== 1'b0)
      $display("FAIL refill_last act=%0d/%b req=6/0", jobs_completed, dispatch_done);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dispatch_done !== 1'b1) $display("FAIL refill_done act=%b req=1", dispatch_done);
    else pass_cnt++;
    enabled = 1'b0;
    tick();
    total_cnt++;
    if (dispatch_done !== 1'b0) $display("FAIL refill_release act=%b req=0", dispatch_done);
    else pass_cnt++;
  endtask

  task automatic test_protocol_error();
    apply_reset();
    enabled = 1'b1; num_vertices = 32'd3;
    tick(); tick();
    job_in_valid = 1'b1; job_in = rand_job();
    tick();
    job_in_valid = 1'b0; cu_done = 4'b0100;
    tick(); cu_done = '0;
    total_cnt++;
    if (protocol_error !== 1'b1 || jobs_completed !== 32'd0)
      $display("FAIL perr_set act=%b/%0d req=1/0", protocol_error, jobs_completed);
    else pass_cnt++;
    cu_done = 4'b0001;
    tick(); cu_done = '0;
    total_cnt++;
    if (protocol_error !== 1'b1 || jobs_completed !== 32'd1)
      $display("FAIL perr_sticky act=%b/%0d req=1/1", protocol_error, jobs_completed);
    else pass_cnt++;
    enabled = 1'b0;
    tick();
    total_cnt++;
    if (protocol_error !== 1'b1) $display("FAIL perr_idle act=%b req=1", protocol_error);
    else pass_cnt++;
    enabled = 1'b1;
    tick();
    total_cnt++;
    if (protocol_error !== 1'b0 || jobs_completed !== 32'd0)
      $display("FAIL perr_clear act=%b/%0d req=0/0", protocol_error, jobs_completed);
    else pass_cnt++;
    enabled = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    enabled = 1'b1; num_vertices = 32'd8;
    tick(); tick();
    job_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin job_in = rand_job(); tick(); end
    job_in_valid = 1'b0; cu_done = 4'b0010;
    tick();
    cu_done = 4'b1001; job_in_valid = 1'b1; job_in = rand_job();
    tick(); cu_done = '0;
    total_cnt++;
    if (cu_job_valid !== 4'b0010 || jobs_completed !== 32'd3)
      $display("FAIL simul_grant act=%b/%0d req=0010/3", cu_job_valid, jobs_completed);
    else pass_cnt++;
    job_in = rand_job();
    tick();
    total_cnt++;
    if (cu_job_valid !== 4'b1000) $display("FAIL simul_next act=%b req=1000", cu_job_valid);
    else pass_cnt++;
    job_in_valid = 1'b0; enabled = 1'b0;
    tick();
  endtask

  task automatic test_zero_jobs();
    apply_reset();
    enabled = 1'b1; num_vertices = 32'd0; job_in_valid = 1'b1; job_in = rand_job();
    tick();
    total_cnt++;
    if (dispatch_done !== 1'b0 || job_in_ready !== 1'b0)
      $display("FAIL zero_setup act=%b/%b req=0/0", dispatch_done, job_in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dispatch_done !== 1'b1 || cu_job_valid !== 4'b0 || job_in_ready !== 1'b0)
      $display("FAIL zero_done act=%b/%b/%b req=1/0000/0", dispatch_done, cu_job_valid, job_in_ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (dispatch_done !== 1'b1 || cu_job_valid !== 4'b0)
      $display("FAIL zero_hold act=%b/%b req=1/0000", dispatch_done, cu_job_valid);
    else pass_cnt++;
    enabled = 1'b0; job_in_valid = 1'b0;
    tick();
    total_cnt++;
    if (dispatch_done !== 1'b0 || dbg_state !== ST_IDLE)
      $display("FAIL zero_release act=%b/%0d req=0/%0d", dispatch_done, dbg_state, ST_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    enabled = 1'b1; num_vertices = 32'd10;
    tick(); tick();
    job_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin job_in = rand_job(); tick(); end
    @(negedge clock);
    rstn = 1'b0;
    #1;
    total_cnt++;
    if ({cu_job_valid, cu_job, job_in_ready, jobs_completed, dispatch_done, protocol_error} !== '0 ||
        dbg_state !== ST_IDLE)
      $display("FAIL midreset_outputs act valid=%b job=%h rdy=%b state=%0d req all 0",
               cu_job_valid, cu_job, job_in_ready, dbg_state);
    else pass_cnt++;
    model_reset();
    enabled = 1'b0; job_in_valid = 1'b0;
    @(negedge clock);
    rstn = 1'b1;
    @(posedge clock);
    #1;
    enabled = 1'b1; num_vertices = 32'd2;
    tick(); tick();
    job_in_valid = 1'b1; job_in = rand_job();
    tick();
    total_cnt++;
    if (cu_job_valid !== 4'b0001) $display("FAIL midreset_first act=%b req=0001", cu_job_valid);
    else pass_cnt++;
    job_in = rand_job();
    tick();
    total_cnt++;
    if (cu_job_valid !== 4'b0010) $display("FAIL midreset_busy_clear act=%b req=0010", cu_job_valid);
    else pass_cnt++;
    job_in_valid = 1'b0; enabled = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [95:0] exp_job;
    bit finished;
    for (int run = 0; run < 4; run++) begin
      enabled = 1'b0; job_in_valid = 1'b0; cu_done = '0;
      tick();
      exp_q.delete();
      enabled = 1'b1; num_vertices = 32'($urandom_range(1, 24));
      tick();
      finished = 1'b0;
      for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
        job_in_valid = 1'($urandom_range(0, 1));
        job_in = rand_job();
        cu_done = 4'($urandom_range(0, 15)) & m_busy;
        #1;
        total_cnt++;
        if (job_in_ready !== m_ready())
          $display("FAIL rand_ready run%0d cyc%0d act=%b req=%b", run, cyc, job_in_ready, m_ready());
        else pass_cnt++;
        tick();
        cu_done = '0;
        total_cnt++;
        if (cu_job_valid !== m_valid)
          $display("FAIL rand_valid run%0d cyc%0d act=%b req=%b", run, cyc, cu_job_valid, m_valid);
        else pass_cnt++;
        if (cu_job_valid !== '0) begin
          total_cnt++;
          if (exp_q.size() == 0) $display("FAIL rand_job run%0d cyc%0d act=%h req=<none>", run, cyc, cu_job);
          else begin
            exp_job = exp_q.pop_front();
            if (cu_job !== exp_job) $display("FAIL rand_job run%0d cyc%0d act=%h req=%h", run, cyc, cu_job, exp_job);
            else pass_cnt++;
          end
        end
        total_cnt++;
        if (jobs_completed !== m_comp || dispatch_done !== (m_phase == P_DONE) || protocol_error !== m_err)
          $display("FAIL rand_status run%0d cyc%0d act=%0d/%b/%b req=%0d/%b/%b", run, cyc,
                   jobs_completed, dispatch_done, protocol_error, m_comp, (m_phase == P_DONE), m_err);
        else pass_cnt++;
        if (m_phase == P_DONE) finished = 1'b1;
      end
      total_cnt++;
      if (!finished || dispatch_done !== 1'b1)
        $display("FAIL rand_timeout run%0d act=%b req=1", run, dispatch_done);
      else pass_cnt++;
    end
    enabled = 1'b0; job_in_valid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_refill();
    test_protocol_error();
    test_simultaneous();
    test_zero_jobs();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
